// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - shared encodings and default latencies for the mul/div sequencer
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int MUL_LAT_DEF = 3;
  localparam int DIV_LAT_DEF = 29;

  function automatic logic is_div(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_lat_cnt.sv
// rtl/muldiv_lat_cnt.sv - loadable down-counter flagging the last cycle of an IP latency
module muldiv_lat_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic             clear,
  input  logic [CNT_W-1:0] load_val,
  output logic             last
);

  logic [CNT_W-1:0] count;

  // clear wins over load so a flush in the accepting cycle leaves the counter idle
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - sequences the shared mul/div IPs for EXE and stages the HI/LO result
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_rs,
  input  logic [31:0] req_rt,
  input  logic        flush,
  input  logic        ready,
  output logic [31:0] ip_a,
  output logic [31:0] ip_b,
  input  logic [63:0] mul_p,
  input  logic [63:0] mulu_p,
  input  logic [63:0] div_qr,
  input  logic [63:0] divu_qr,
  output logic        complete,
  output logic        res_valid,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  state_e           state;
  op_e              op_r;
  logic             accept;
  logic             last;
  logic [CNT_W-1:0] lat_val;

  assign accept  = (state == ST_IDLE) && req_valid && !flush;
  assign lat_val = is_div(op_e'(req_op)) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

  muldiv_lat_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .en       (state == ST_BUSY),
    .clear    (flush),
    .load_val (lat_val),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_r      <= OP_MULT;
      ip_a      <= '0;
      ip_b      <= '0;
      res_hi    <= '0;
      res_lo    <= '0;
      res_valid <= 1'b0;
    end else if (flush) begin
      state     <= ST_IDLE;
      res_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            ip_a  <= req_rs;
            ip_b  <= req_rt;
            op_r  <= op_e'(req_op);
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (last) begin
            // dividers return {quotient, remainder}; LO takes the quotient
            unique case (op_r)
              OP_MULT:  {res_hi, res_lo} <= mul_p;
              OP_MULTU: {res_hi, res_lo} <= mulu_p;
              OP_DIV:   {res_lo, res_hi} <= div_qr;
              OP_DIVU:  {res_lo, res_hi} <= divu_qr;
            endcase
            res_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    complete = 1'b1;
    unique case (state)
      ST_IDLE: complete = !req_valid || flush;
      ST_BUSY: complete = 1'b0;
      ST_DONE: complete = 1'b1;
      default: complete = 1'b1;
    endcase
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequences the shared multiply/divide IP cores (signed and unsigned multiplier, signed and unsigned divider) for the EXE stage.
- Holds the operands stable for the whole IP latency and counts cycles to completion.
- Captures the 64-bit result into HI/LO staging registers and tells the pipeline when EXE may advance.
- Replaces the ad-hoc start/counter logic inside EXE, and adds flush-cancel and a hold-until-accepted result.

Parameters:
- MUL_LAT, 3, cycles from operand launch to a valid multiplier product (must be ≥1).
- DIV_LAT, 29, cycles from operand launch to a valid divider quotient/remainder (must be ≥1).
- CNT_W, 6, counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  EXE holds a mult/multu/div/divu instruction
- req_op  in  2  0=MULT 1=MULTU 2=DIV 3=DIVU
- req_rs  in  32  rs operand (multiplicand / dividend)
- req_rt  in  32  rt operand (multiplier / divisor)
- flush  in  1  exception flush; cancels any operation
- ready  in  1  downstream pipeline accepts EXE this cycle
- ip_a  out  32  registered operand A to all four IPs
- ip_b  out  32  registered operand B to all four IPs
- mul_p  in  64  signed multiplier product {hi,lo}
- mulu_p  in  64  unsigned multiplier product {hi,lo}
- div_qr  in  64  signed divider {quotient,remainder}
- divu_qr  in  64  unsigned divider {quotient,remainder}
- complete  out  1  EXE may advance (0 = stall)
- res_valid  out  1  HI/LO result ready for writeback
- res_hi  out  32  HI value (product high word / remainder)
- res_lo  out  32  LO value (product low word / quotient)

Behaviour:
- Reset values:
  - State IDLE, counter 0.
  - ip_a, ip_b, res_hi, res_lo = 0.
  - res_valid = 0.
  - complete = 1 (combinational, resolves to 1 with req_valid=0).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - req_valid & !flush → latch req_rs→ip_a, req_rt→ip_b and req_op→op_r.
  - Load counter with MUL_LAT (op<2) or DIV_LAT (op≥2), then go BUSY.
- BUSY:
  - Counter decrements each cycle; ip_a/ip_b are held constant.
  - When counter==1, capture the selected IP output and go DONE:
    - mult/multu: res_hi=P[63:32], res_lo=P[31:0].
    - div/divu: res_lo=QR[63:32] (quotient), res_hi=QR[31:0] (remainder).
  - res_valid rises on the first DONE cycle, exactly LAT cycles after the accepting edge.
- DONE:
  - res_valid=1 and the result is held stable until ready=1.
  - On ready: go IDLE and res_valid falls.
  - A new req_valid is not accepted in the same cycle; the next instruction is accepted from IDLE on the following cycle.
- complete:
  - IDLE: complete = !req_valid | flush.
  - BUSY: complete = 0.
  - DONE: complete = 1.
- flush:
  - Asserted in any state → next state IDLE, res_valid=0, counter=0; any in-flight result is discarded.
  - Has priority over req_valid and over the counter==1 capture.
- Divide by zero: no trap; the IP output is passed through unmodified (architecturally undefined).
- Reset mid-BUSY: returns to IDLE in one cycle; the result is never presented.
- No arithmetic is done in this block; it only selects and routes the 64-bit IP outputs.

Decomposition:
- Shared package holds:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU;
  - FSM state encodings;
  - default latencies MUL_LAT_DEF=3, DIV_LAT_DEF=29.
- One natural sub-module: muldiv_lat_cnt, a loadable down-counter with load/enable/clear that outputs a last flag (count==1).
- The IP instances stay in exe_stage; this block only drives ip_a/ip_b and samples the IP outputs.

Test Plan:
- MULT rs=0xFFFFFFFE, rt=3 → complete=0 for 3 cycles; res_valid on cycle 3 with res_hi=0xFFFFFFFF, res_lo=0xFFFFFFFA.
- DIVU rs=100, rt=7 → 29 stall cycles; res_lo=14, res_hi=2; res_valid held while ready=0 for 5 cycles, drops the cycle after ready=1.
- DIV rs=-7, rt=2 → res_lo=0xFFFFFFFD, res_hi=0xFFFFFFFF.
- flush at BUSY cycle 10 of a DIV → IDLE next cycle; res_valid never asserts; a subsequent MULTU 0xFFFFFFFF×2 gives res_hi=1, res_lo=0xFFFFFFFE.
- req_valid with flush in the same cycle → not accepted; state stays IDLE; complete=1.
- Back-to-back MULT then MULTU with ready=1 → second accepted one cycle after first DONE; res_valid pulses twice with the correct values.
